// File: rtl/bar_graph_pkg.sv
// Shared types and constants for the bar graph visuals path.
package bar_graph_pkg;

  localparam int unsigned SCREEN_W = 320;
  localparam int unsigned SCREEN_H = 240;
  localparam int unsigned BAR_W    = 8;
  localparam int unsigned HEIGHT_W = 7;
  localparam int unsigned X_W      = 9;
  localparam int unsigned Y_W      = 8;
  localparam int unsigned IDX_W    = 3;

  typedef logic [HEIGHT_W-1:0] height_t;
  typedef logic [X_W-1:0]      x_t;
  typedef logic [Y_W-1:0]      y_t;
  typedef logic [IDX_W-1:0]    idx_t;
  typedef logic [2:0]          colour_t;

  localparam colour_t DEF_BG_COLOUR  = 3'b000;
  localparam colour_t DEF_BAR_COLOUR = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR_E,
    S_ERASE,
    S_CLR_D,
    S_DRAW,
    S_NEXT,
    S_FIN
  } state_t;

endpackage

// File: rtl/bar_graph_sequencer_if.sv
// Link between the sequencer and the external 8-pixel-wide bar pixel counter.
interface bar_graph_sequencer_if;
  import bar_graph_pkg::*;

  logic    cnt_resetn;
  logic    cnt_enable;
  x_t      cnt_start_x;
  y_t      cnt_start_y;
  height_t cnt_height;
  logic    cnt_done;

  modport master (
    output cnt_resetn, cnt_enable, cnt_start_x, cnt_start_y, cnt_height,
    input  cnt_done
  );

  modport slave (
    input  cnt_resetn, cnt_enable, cnt_start_x, cnt_start_y, cnt_height,
    output cnt_done
  );

endinterface

// File: rtl/bar_height_store.sv
// Bar height register file with clamped write port and a per-frame snapshot.
module bar_height_store
  import bar_graph_pkg::*;
#(
  parameter int unsigned NUM_BARS   = 8,
  parameter int unsigned MAX_HEIGHT = 100
) (
  input  logic    clk,
  input  logic    resetn,
  input  logic    wr_en,
  input  idx_t    wr_idx,
  input  height_t wr_data,
  input  logic    capture,
  input  idx_t    rd_idx,
  output height_t rd_height
);

  localparam height_t MAX_H = height_t'(MAX_HEIGHT);

  height_t file_q [NUM_BARS];
  height_t snap_q [NUM_BARS];
  height_t wr_clamped;

  assign wr_clamped = (wr_data > MAX_H) ? MAX_H : wr_data;

  // Snapshot copies the pre-write file, so a same-cycle write misses this frame.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_BARS; i++) begin
        file_q[i] <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_BARS; i++) begin
        if (wr_en && (32'(wr_idx) == i))
          file_q[i] <= wr_clamped;
        if (capture)
          snap_q[i] <= file_q[i];
      end
    end
  end

  always_comb begin
    rd_height = '0;
    for (int unsigned i = 0; i < NUM_BARS; i++) begin
      if (32'(rd_idx) == i)
        rd_height = snap_q[i];
    end
  end

endmodule

// File: rtl/bar_graph_sequencer.sv
// Frame sequencer: erases then redraws each bar via the external pixel counter.
module bar_graph_sequencer
  import bar_graph_pkg::*;
#(
  parameter int unsigned NUM_BARS   = 8,
  parameter int unsigned BASE_X     = 40,
  parameter int unsigned BAR_PITCH  = 30,
  parameter int unsigned BASE_Y     = 220,
  parameter int unsigned MAX_HEIGHT = 100,
  parameter colour_t     BG_COLOUR  = DEF_BG_COLOUR,
  parameter colour_t     BAR_COLOUR = DEF_BAR_COLOUR
) (
  input  logic    clk,
  input  logic    resetn,
  input  logic    height_wr_en,
  input  idx_t    height_wr_idx,
  input  height_t height_wr_data,
  input  logic    start,
  output logic    busy,
  output logic    frame_done,
  output logic    plot,
  output colour_t colour,
  bar_graph_sequencer_if.master cnt
);

  localparam height_t MAX_H    = height_t'(MAX_HEIGHT);
  localparam y_t      BASE_Y_V = y_t'(BASE_Y);
  localparam y_t      ERASE_Y  = y_t'(BASE_Y - MAX_HEIGHT);

  state_t  state, state_n;
  idx_t    idx, idx_n;
  logic    capture;
  logic    cnt_clr;
  logic    cnt_en;
  height_t bar_h;

  bar_height_store #(
    .NUM_BARS   (NUM_BARS),
    .MAX_HEIGHT (MAX_HEIGHT)
  ) u_store (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en     (height_wr_en),
    .wr_idx    (height_wr_idx),
    .wr_data   (height_wr_data),
    .capture   (capture),
    .rd_idx    (idx),
    .rd_height (bar_h)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n         = state;
    idx_n           = idx;
    capture         = 1'b0;
    cnt_clr         = 1'b0;
    cnt_en          = 1'b0;
    frame_done      = 1'b0;
    plot            = 1'b0;
    colour          = BG_COLOUR;
    cnt.cnt_height  = MAX_H;
    cnt.cnt_start_y = ERASE_Y;
    case (state)
      S_IDLE: begin
        if (start) begin
          capture = 1'b1;
          idx_n   = '0;
          state_n = S_CLR_E;
        end
      end
      S_CLR_E: begin
        cnt_clr = 1'b1;
        state_n = S_ERASE;
      end
      S_ERASE: begin
        cnt_en = 1'b1;
        plot   = ~cnt.cnt_done;
        if (cnt.cnt_done)
          state_n = S_CLR_D;
      end
      S_CLR_D: begin
        cnt_clr = 1'b1;
        state_n = S_DRAW;
      end
      S_DRAW: begin
        cnt_en          = 1'b1;
        plot            = ~cnt.cnt_done;
        colour          = BAR_COLOUR;
        cnt.cnt_height  = bar_h;
        cnt.cnt_start_y = BASE_Y_V - y_t'(bar_h);
        if (cnt.cnt_done)
          state_n = S_NEXT;
      end
      S_NEXT: begin
        if (32'(idx) == NUM_BARS - 1) begin
          state_n = S_FIN;
        end else begin
          idx_n   = idx + idx_t'(1);
          state_n = S_CLR_E;
        end
      end
      S_FIN: begin
        frame_done = 1'b1;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Counter is held in reset with the sequencer and pulsed before each phase.
  assign busy            = (state != S_IDLE);
  assign cnt.cnt_resetn  = resetn & ~cnt_clr;
  assign cnt.cnt_enable  = cnt_en;
  assign cnt.cnt_start_x = x_t'(BASE_X + 32'(idx) * BAR_PITCH);

endmodule

// File: tb/tb_bar_graph_sequencer.sv
// Directed bench for bar_graph_sequencer with a behavioural 8-wide pixel counter.
module tb_bar_graph_sequencer;
  import bar_graph_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic       height_wr_en;
  logic [2:0] height_wr_idx;
  logic [6:0] height_wr_data;
  logic       start;
  logic       busy;
  logic       frame_done;
  logic       plot;
  logic [2:0] colour;

  always #5 clk = ~clk;

  bar_graph_sequencer_if cnt_bus();

  bar_graph_sequencer #(
    .NUM_BARS   (8),
    .BASE_X     (40),
    .BAR_PITCH  (30),
    .BASE_Y     (220),
    .MAX_HEIGHT (100),
    .BG_COLOUR  (3'b000),
    .BAR_COLOUR (3'b010)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .height_wr_en   (height_wr_en),
    .height_wr_idx  (height_wr_idx),
    .height_wr_data (height_wr_data),
    .start          (start),
    .busy           (busy),
    .frame_done     (frame_done),
    .plot           (plot),
    .colour         (colour),
    .cnt            (cnt_bus)
  );

  // Pixel counter: x offset 0..7 fastest, y offset 0..h, done registered after last pixel.
  logic [2:0] xo;
  logic [6:0] yo;
  logic       cdone;

  always @(posedge clk) begin
    if (!cnt_bus.cnt_resetn) begin
      xo    <= '0;
      yo    <= '0;
      cdone <= 1'b0;
    end else if (cnt_bus.cnt_enable && !cdone) begin
      if (xo == 3'd7) begin
        xo <= '0;
        if (yo == cnt_bus.cnt_height) cdone <= 1'b1;
        else                          yo <= yo + 7'd1;
      end else begin
        xo <= xo + 3'd1;
      end
    end
  end
  assign cnt_bus.cnt_done = cdone;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Frame statistics gathered on the falling edge.
  int bg_plots, bar_total, busy_cyc, fd_cnt;
  int bar_plots [8];
  int minx [8];
  int maxx [8];
  int miny [8];
  int maxy [8];
  int draw_h [8];
  int draw_sy [8];
  int mon_px, mon_py, mon_b;

  task automatic clear_stats();
    bg_plots  = 0;
    bar_total = 0;
    busy_cyc  = 0;
    fd_cnt    = 0;
    for (int i = 0; i < 8; i++) begin
      bar_plots[i] = 0;
      minx[i] = 9999; maxx[i] = -1;
      miny[i] = 9999; maxy[i] = -1;
      draw_h[i] = -1; draw_sy[i] = -1;
    end
  endtask

  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (frame_done) fd_cnt++;
    if (plot) begin
      mon_px = int'(cnt_bus.cnt_start_x) + int'(xo);
      mon_py = int'(cnt_bus.cnt_start_y) + int'(yo);
      if (colour == 3'b010) begin
        bar_total++;
        mon_b = (mon_px - 40) / 30;
        if (mon_b >= 0 && mon_b < 8) begin
          bar_plots[mon_b]++;
          if (mon_px < minx[mon_b]) minx[mon_b] = mon_px;
          if (mon_px > maxx[mon_b]) maxx[mon_b] = mon_px;
          if (mon_py < miny[mon_b]) miny[mon_b] = mon_py;
          if (mon_py > maxy[mon_b]) maxy[mon_b] = mon_py;
          draw_h[mon_b]  = int'(cnt_bus.cnt_height);
          draw_sy[mon_b] = int'(cnt_bus.cnt_start_y);
        end
      end else if (colour == 3'b000) begin
        bg_plots++;
      end
    end
  end

  task automatic write_height(input int idx, input int data);
    @(negedge clk);
    height_wr_en   = 1'b1;
    height_wr_idx  = 3'(idx);
    height_wr_data = 7'(data);
    @(negedge clk);
    height_wr_en   = 1'b0;
  endtask

  task automatic start_frame(input string tag);
    clear_stats();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
    check({tag, "_clr_e_resetn"}, cnt_bus.cnt_resetn, 0);
    check({tag, "_clr_e_plot"}, plot, 0);
    @(negedge clk);
    check({tag, "_first_plot"}, plot, 1);
    check({tag, "_first_x"}, int'(cnt_bus.cnt_start_x) + int'(xo), 40);
    check({tag, "_first_y"}, int'(cnt_bus.cnt_start_y) + int'(yo), 120);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    #1;
    check({tag, "_idle_timeout"}, busy, 0);
  endtask

  task automatic wait_bar(input string tag, input int x, input bit in_draw);
    int n = 0;
    while (!(int'(cnt_bus.cnt_start_x) == x && (!in_draw || (plot && colour == 3'b010)))
           && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reached"}, (n < 20000) ? 1 : 0, 1);
  endtask

  task automatic check_frame(input string tag, input int h [8]);
    int exp_busy = 1;
    for (int i = 0; i < 8; i++) exp_busy += 821 + 8 * h[i];
    check({tag, "_busy_cycles"}, busy_cyc, exp_busy);
    check({tag, "_frame_done"}, fd_cnt, 1);
    check({tag, "_bg_plots"}, bg_plots, 8 * 808);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_bar%0d_plots", tag, i), bar_plots[i], 8 * (h[i] + 1));
  endtask

  int hz [8];
  int h1 [8];
  int h2 [8];

  initial begin
    resetn         = 1'b0;
    start          = 1'b0;
    height_wr_en   = 1'b0;
    height_wr_idx  = '0;
    height_wr_data = '0;
    clear_stats();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_plot", plot, 0);
    check("rst_cnt_resetn", cnt_bus.cnt_resetn, 0);
    check("rst_cnt_enable", cnt_bus.cnt_enable, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_colour", colour, 3'b000);
    check("rst_start_x", cnt_bus.cnt_start_x, 40);
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_cnt_resetn", cnt_bus.cnt_resetn, 1);
    check("post_rst_busy", busy, 0);

    // All heights zero
    for (int i = 0; i < 8; i++) hz[i] = 0;
    start_frame("zero");
    wait_idle("zero");
    check_frame("zero", hz);
    check("zero_bar_total", bar_total, 64);
    for (int i = 0; i < 8; i++)
      check($sformatf("zero_bar%0d_height", i), draw_h[i], 0);

    // Bar 3 at full height
    write_height(3, 100);
    h1 = hz;
    h1[3] = 100;
    start_frame("bar3");
    wait_idle("bar3");
    check_frame("bar3", h1);
    check("bar3_minx", minx[3], 130);
    check("bar3_maxx", maxx[3], 137);
    check("bar3_miny", miny[3], 120);
    check("bar3_maxy", maxy[3], 220);

    // Bar 5 written above the clamp
    write_height(5, 127);
    h1[5] = 100;
    start_frame("bar5");
    wait_idle("bar5");
    check_frame("bar5", h1);
    check("bar5_cnt_height", draw_h[5], 100);
    check("bar5_start_y", draw_sy[5], 120);

    // Mid-frame start and write of bar 0
    start_frame("mid");
    wait_bar("mid_bar2", 100, 1'b0);
    start          = 1'b1;
    height_wr_en   = 1'b1;
    height_wr_idx  = 3'd0;
    height_wr_data = 7'd50;
    @(negedge clk);
    start        = 1'b0;
    height_wr_en = 1'b0;
    wait_idle("mid");
    check_frame("mid", h1);
    repeat (3) @(negedge clk);
    check("mid_no_restart", busy, 0);
    h2 = h1;
    h2[0] = 50;
    start_frame("after");
    wait_idle("after");
    check_frame("after", h2);
    check("after_bar0_height", draw_h[0], 50);
    check("after_bar0_start_y", draw_sy[0], 170);

    // Reset during bar 4 DRAW
    start_frame("abort");
    wait_bar("abort_bar4_draw", 160, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_plot", plot, 0);
    check("abort_cnt_resetn", cnt_bus.cnt_resetn, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("abort_no_frame_done", fd_cnt, 0);
    check("abort_idle", busy, 0);
    start_frame("recover");
    wait_idle("recover");
    check_frame("recover", hz);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
